// File: rtl/rti_unwind_sequencer.sv
// rtl/rti_unwind_sequencer.sv - stack unwind sequencer for RTI/RET
// Pops saved flags and PC back off the stack, freezing the pipeline until the redirect strobe.
module rti_unwind_sequencer #(
    parameter int DATA_W   = 16,
    parameter int FLAG_W   = 3,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rti_req,
    input  logic              ret_req,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_pop,
    output logic              mem_read,
    output logic              stall,
    output logic              busy,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out,
    output logic              flags_load,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flag_err
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP_FLAGS,
        WAIT_FLAGS,
        POP_PC,
        WAIT_PC,
        REDIRECT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] latCnt;
    logic             modeRti;
    logic             memPopQ;
    logic             busyQ;
    logic             pcLoadQ;
    logic             flagsLoadQ;

    // Outputs are registered alongside the transition into the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            latCnt     <= '0;
            modeRti    <= 1'b0;
            memPopQ    <= 1'b0;
            busyQ      <= 1'b0;
            pcLoadQ    <= 1'b0;
            flagsLoadQ <= 1'b0;
            pc_out     <= '0;
            flags_out  <= '0;
            flag_err   <= 1'b0;
        end else begin
            pcLoadQ    <= 1'b0;
            flagsLoadQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (rti_req) begin
                        state   <= POP_FLAGS;
                        modeRti <= 1'b1;
                        memPopQ <= 1'b1;
                        busyQ   <= 1'b1;
                    end else if (ret_req) begin
                        state   <= POP_PC;
                        modeRti <= 1'b0;
                        memPopQ <= 1'b1;
                        busyQ   <= 1'b1;
                    end
                end
                POP_FLAGS: begin
                    if (mem_ready) begin
                        state   <= WAIT_FLAGS;
                        latCnt  <= LAT_RELOAD;
                        memPopQ <= 1'b0;
                    end
                end
                WAIT_FLAGS: begin
                    if (latCnt == '0) begin
                        flags_out <= mem_rdata[FLAG_W-1:0];
                        flag_err  <= flag_err | (|mem_rdata[DATA_W-1:FLAG_W]);
                        state     <= POP_PC;
                        memPopQ   <= 1'b1;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                POP_PC: begin
                    if (mem_ready) begin
                        state   <= WAIT_PC;
                        latCnt  <= LAT_RELOAD;
                        memPopQ <= 1'b0;
                    end
                end
                WAIT_PC: begin
                    if (latCnt == '0) begin
                        pc_out     <= mem_rdata;
                        state      <= REDIRECT;
                        pcLoadQ    <= 1'b1;
                        flagsLoadQ <= modeRti;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                REDIRECT: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    memPopQ <= 1'b0;
                    busyQ   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_pop    = memPopQ;
    assign mem_read   = memPopQ;
    assign busy       = busyQ;
    assign pc_load    = pcLoadQ;
    assign flags_load = flagsLoadQ;
    // Request-cycle freeze must not leak out while reset is asserted.
    assign stall      = busyQ | ((rti_req | ret_req) & ~rst);

endmodule

// File: tb/tb_rti_unwind_sequencer.sv
// tb/tb_rti_unwind_sequencer.sv - scoreboard bench for rti_unwind_sequencer
module tb_rti_unwind_sequencer;

    typedef struct {
        logic [15:0] pc;
        logic        fl;
        logic [2:0]  flags;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memReady = 1'b1;
    logic        rtiA = 1'b0, retA = 1'b0, rtiB = 1'b0, retB = 1'b0;
    logic [15:0] rdataA, rdataB, pcOutA, pcOutB;
    logic        popA, readA, stallA, busyA, pcLoadA, flagsLoadA, flagErrA;
    logic        popB, readB, stallB, busyB, pcLoadB, flagsLoadB, flagErrB;
    logic [2:0]  flagsOutA, flagsOutB;

    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   accA = 0;
    int   popCycA[$];
    logic [15:0] stackA[$];
    logic [15:0] stackB[$];
    exp_t expA[$];
    exp_t expB[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rti_unwind_sequencer #(.DATA_W(16), .FLAG_W(3), .READ_LAT(1)) dutA (
        .clk(clk), .rst(rst), .rti_req(rtiA), .ret_req(retA), .mem_ready(memReady),
        .mem_rdata(rdataA), .mem_pop(popA), .mem_read(readA), .stall(stallA), .busy(busyA),
        .pc_load(pcLoadA), .pc_out(pcOutA), .flags_load(flagsLoadA), .flags_out(flagsOutA),
        .flag_err(flagErrA)
    );

    rti_unwind_sequencer #(.DATA_W(16), .FLAG_W(3), .READ_LAT(3)) dutB (
        .clk(clk), .rst(rst), .rti_req(rtiB), .ret_req(retB), .mem_ready(memReady),
        .mem_rdata(rdataB), .mem_pop(popB), .mem_read(readB), .stall(stallB), .busy(busyB),
        .pc_load(pcLoadB), .pc_out(pcOutB), .flags_load(flagsLoadB), .flags_out(flagsOutB),
        .flag_err(flagErrB)
    );

    // Stack memory models: data is valid only exactly READ_LAT cycles after acceptance.
    logic [15:0] wordA, wordB;
    int ageA, ageB;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ageA  <= 0;
            wordA <= 16'h0;
        end else if (popA && memReady) begin
            if (stackA.size() > 0) wordA <= stackA.pop_front();
            else wordA <= 16'hDEAD;
            ageA <= 1;
        end else if (ageA != 0 && ageA < 8) begin
            ageA <= ageA + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ageB  <= 0;
            wordB <= 16'h0;
        end else if (popB && memReady) begin
            if (stackB.size() > 0) wordB <= stackB.pop_front();
            else wordB <= 16'hDEAD;
            ageB <= 1;
        end else if (ageB != 0 && ageB < 8) begin
            ageB <= ageB + 1;
        end
    end

    assign rdataA = (ageA == 1) ? wordA : 16'hBEEF;
    assign rdataB = (ageB == 3) ? wordB : 16'hBEEF;

    task automatic check(input string nm, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkPops(input string nm, input int c0, input int n,
                             input int o0, input int o1, input int o2, input int o3, input int o4);
        int offs[5];
        offs = '{o0, o1, o2, o3, o4};
        check({nm, "_pop_count"}, popCycA.size(), n);
        for (int i = 0; i < n && i < popCycA.size(); i++)
            check({nm, "_pop_cycle"}, popCycA[i] - c0, offs[i]);
        popCycA.delete();
    endtask

    // Monitors: every redirect strobe pops one expected unwind and compares it.
    always @(negedge clk) begin
        if (!rst) begin
            if (popA) popCycA.push_back(cyc);
            if (popA && memReady) accA++;
            if (popA || readA) check("mem_read_eq_pop_a", readA, popA);
            if (pcLoadA) begin
                if (expA.size() == 0) check("unexpected_pc_load_a", 1, 0);
                else begin
                    exp_t e;
                    e = expA.pop_front();
                    check("pc_out_a", pcOutA, e.pc);
                    check("flags_load_a", flagsLoadA, e.fl);
                    check("flags_out_a", flagsOutA, e.flags);
                    check("flag_err_a", flagErrA, e.err);
                    check("pc_load_cycle_a", cyc, e.cyc);
                end
            end else if (flagsLoadA) check("stray_flags_load_a", 1, 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pcLoadB) begin
                if (expB.size() == 0) check("unexpected_pc_load_b", 1, 0);
                else begin
                    exp_t e;
                    e = expB.pop_front();
                    check("pc_out_b", pcOutB, e.pc);
                    check("flags_load_b", flagsLoadB, e.fl);
                    check("flags_out_b", flagsOutB, e.flags);
                    check("flag_err_b", flagErrB, e.err);
                    check("pc_load_cycle_b", cyc, e.cyc);
                end
            end else if (flagsLoadB) check("stray_flags_load_b", 1, 0);
        end
    end

    initial begin
        int c0;
        int acc0;

        #2;
        check("rst_pc_out", pcOutA, 0);
        check("rst_flags_out", flagsOutA, 0);
        check("rst_flag_err", flagErrA, 0);
        check("rst_busy", busyA, 0);
        check("rst_stall", stallA, 0);
        check("rst_mem_pop", popA, 0);
        check("rst_pc_load", pcLoadA, 0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // RTI, READ_LAT=1, memory always ready
        stackA = '{16'h0005, 16'h01A4};
        popCycA.delete();
        c0 = cyc;
        rtiA = 1'b1;
        expA.push_back('{pc: 16'h01A4, fl: 1'b1, flags: 3'b101, err: 1'b0, cyc: c0 + 5});
        #1 check("t1_stall_req_cycle", stallA, 1);
        tick(1);
        rtiA = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("t1_stall_held", stallA, 1);
            check("t1_busy_held", busyA, 1);
            tick(1);
        end
        check("t1_busy_done", busyA, 0);
        check("t1_stall_done", stallA, 0);
        check("t1_pending", expA.size(), 0);
        checkPops("t1", c0, 2, 1, 3, 0, 0, 0);

        // RET pops only the PC and leaves flags alone
        stackA = '{16'h0033};
        c0 = cyc;
        retA = 1'b1;
        expA.push_back('{pc: 16'h0033, fl: 1'b0, flags: 3'b101, err: 1'b0, cyc: c0 + 3});
        tick(1);
        retA = 1'b0;
        tick(4);
        check("t2_busy_done", busyA, 0);
        check("t2_pending", expA.size(), 0);
        checkPops("t2", c0, 1, 1, 0, 0, 0, 0);

        // Memory back-pressure for three cycles on the flags pop
        stackA = '{16'h0006, 16'h0100};
        c0 = cyc;
        acc0 = accA;
        rtiA = 1'b1;
        memReady = 1'b0;
        expA.push_back('{pc: 16'h0100, fl: 1'b1, flags: 3'b110, err: 1'b0, cyc: c0 + 8});
        tick(1);
        rtiA = 1'b0;
        tick(3);
        memReady = 1'b1;
        tick(6);
        check("t3_pending", expA.size(), 0);
        check("t3_accepts", accA - acc0, 2);
        checkPops("t3", c0, 5, 1, 2, 3, 4, 6);

        // READ_LAT=3 with dirty flag word, then a clean RET keeps flag_err sticky
        stackB = '{16'h8002, 16'h0200};
        c0 = cyc;
        rtiB = 1'b1;
        expB.push_back('{pc: 16'h0200, fl: 1'b1, flags: 3'b010, err: 1'b1, cyc: c0 + 9});
        tick(1);
        rtiB = 1'b0;
        tick(10);
        check("t4_busy_done", busyB, 0);
        stackB = '{16'h0044};
        c0 = cyc;
        retB = 1'b1;
        expB.push_back('{pc: 16'h0044, fl: 1'b0, flags: 3'b010, err: 1'b1, cyc: c0 + 5});
        tick(1);
        retB = 1'b0;
        tick(6);
        check("t4_pending", expB.size(), 0);
        check("t4_flag_err_sticky", flagErrB, 1);

        // Simultaneous requests: RTI wins, later ret_req while busy is dropped
        stackA = '{16'h0001, 16'h0ABC};
        popCycA.delete();
        c0 = cyc;
        rtiA = 1'b1;
        retA = 1'b1;
        expA.push_back('{pc: 16'h0ABC, fl: 1'b1, flags: 3'b001, err: 1'b0, cyc: c0 + 5});
        tick(1);
        rtiA = 1'b0;
        retA = 1'b0;
        tick(1);
        retA = 1'b1;
        tick(1);
        retA = 1'b0;
        tick(7);
        check("t5_pending", expA.size(), 0);
        check("t5_stack_left", stackA.size(), 0);
        check("t5_busy_done", busyA, 0);
        checkPops("t5", c0, 2, 1, 3, 0, 0, 0);

        // Async reset in WAIT_PC abandons the unwind with no strobe
        stackA = '{16'h0002, 16'h0300};
        c0 = cyc;
        rtiA = 1'b1;
        tick(1);
        rtiA = 1'b0;
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", busyA, 0);
        check("t6_rst_stall", stallA, 0);
        check("t6_rst_pc_out", pcOutA, 0);
        check("t6_rst_flags_out", flagsOutA, 0);
        check("t6_rst_pc_load", pcLoadA, 0);
        check("t6_rst_mem_pop", popA, 0);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("t6_idle_after_rst", busyA, 0);
        stackA = '{16'h0004, 16'h0400};
        popCycA.delete();
        c0 = cyc;
        rtiA = 1'b1;
        expA.push_back('{pc: 16'h0400, fl: 1'b1, flags: 3'b100, err: 1'b0, cyc: c0 + 5});
        tick(1);
        rtiA = 1'b0;
        tick(7);
        check("t6_pending", expA.size(), 0);
        checkPops("t6", c0, 2, 1, 3, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
